// File: rtl/axil_pkg.sv
// Shared constants and types for the single-outstanding AXI4-Lite command initiator.
package axil_pkg;

   localparam int unsigned DEF_ADDR_W = 6;
   localparam int unsigned DEF_DATA_W = 32;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WRESP,
      RADDR,
      RDATA,
      RSP
   } axilState_t;

   typedef struct packed {
      logic                    write;
      logic [DEF_ADDR_W-1:0]   addr;
      logic [DEF_DATA_W-1:0]   wdata;
      logic [DEF_DATA_W/8-1:0] wstrb;
   } axilCmd_t;

endpackage

// File: rtl/axil_wd_timer.sv
// Saturating watchdog for axil_master_cmd; instantiated only when AXIL_MASTER_TIMEOUT_EN is defined.
// expired_c fires combinationally during the TIMEOUT_CYC-th enabled cycle since the last clear.
module axil_wd_timer #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != CNT_W'(TIMEOUT_CYC))) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired_c = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/axil_master_cmd.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready register-command stream.
// Define AXIL_MASTER_TIMEOUT_EN to add a watchdog that answers SLVERR after TIMEOUT_CYC stalled cycles.
module axil_master_cmd
   import axil_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                clock,
   input  logic                reset,

   input  logic                io_cmd_valid,
   output logic                io_cmd_ready,
   input  logic                io_cmd_write,
   input  logic [ADDR_W-1:0]   io_cmd_addr,
   input  logic [DATA_W-1:0]   io_cmd_wdata,
   input  logic [DATA_W/8-1:0] io_cmd_wstrb,

   output logic                io_rsp_valid,
   input  logic                io_rsp_ready,
   output logic [DATA_W-1:0]   io_rsp_rdata,
   output logic [1:0]          io_rsp_resp,
   output logic                io_rsp_write,

   output logic [ADDR_W-1:0]   io_axiLite_awaddr,
   output logic [2:0]          io_axiLite_awprot,
   output logic                io_axiLite_awvalid,
   input  logic                io_axiLite_awready,
   output logic [DATA_W-1:0]   io_axiLite_wdata,
   output logic [DATA_W/8-1:0] io_axiLite_wstrb,
   output logic                io_axiLite_wvalid,
   input  logic                io_axiLite_wready,
   input  logic [1:0]          io_axiLite_bresp,
   input  logic                io_axiLite_bvalid,
   output logic                io_axiLite_bready,
   output logic [ADDR_W-1:0]   io_axiLite_araddr,
   output logic [2:0]          io_axiLite_arprot,
   output logic                io_axiLite_arvalid,
   input  logic                io_axiLite_arready,
   input  logic [DATA_W-1:0]   io_axiLite_rdata,
   input  logic [1:0]          io_axiLite_rresp,
   input  logic                io_axiLite_rvalid,
   output logic                io_axiLite_rready
);

   localparam int unsigned STRB_W = DATA_W / 8;

   if (TIMEOUT_CYC < 2) begin : gBadTimeout
      $error("TIMEOUT_CYC must be at least 2");
   end

   axilState_t state, stateNext;
   logic awDone, awDoneNext, wDone, wDoneNext;
   logic cmdFire, awFire, wFire, bFire, arFire, rFire, timeoutHit;

   logic              cmdWrite;
   logic [ADDR_W-1:0] cmdAddr;
   logic [DATA_W-1:0] cmdWdata;
   logic [STRB_W-1:0] cmdWstrb;
   logic [DATA_W-1:0] rspRdata;
   logic [1:0]        rspResp;

   assign cmdFire = io_cmd_valid && io_cmd_ready;
   assign awFire  = io_axiLite_awvalid && io_axiLite_awready;
   assign wFire   = io_axiLite_wvalid && io_axiLite_wready;
   assign bFire   = io_axiLite_bvalid && io_axiLite_bready;
   assign arFire  = io_axiLite_arvalid && io_axiLite_arready;
   assign rFire   = io_axiLite_rvalid && io_axiLite_rready;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam logic LATE_DRAIN = 1'b1;
   logic timerEnable;

   assign timerEnable = (state == WADDR) || (state == WRESP) ||
                        (state == RADDR) || (state == RDATA);

   axil_wd_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) uWdTimer (
      .clock     (clock),
      .reset     (reset),
      .clear     (stateNext != state),
      .enable    (timerEnable),
      .expired_c (timeoutHit)
   );
`else
   localparam logic LATE_DRAIN = 1'b0;
   assign timeoutHit = 1'b0;
`endif

   // Next-state and AW/W completion tracking
   always_comb begin
      stateNext  = state;
      awDoneNext = awDone;
      wDoneNext  = wDone;
      unique case (state)
         IDLE: begin
            if (cmdFire) begin
               stateNext  = io_cmd_write ? WADDR : RADDR;
               awDoneNext = 1'b0;
               wDoneNext  = 1'b0;
            end
         end
         WADDR: begin
            if (awFire) awDoneNext = 1'b1;
            if (wFire)  wDoneNext  = 1'b1;
            if (awDoneNext && wDoneNext) stateNext = WRESP;
         end
         WRESP:   if (bFire)        stateNext = RSP;
         RADDR:   if (arFire)       stateNext = RDATA;
         RDATA:   if (rFire)        stateNext = RSP;
         RSP:     if (io_rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      if (timeoutHit) stateNext = RSP;
   end

   // State, captured command/response and registered handshake outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state              <= IDLE;
         awDone             <= 1'b0;
         wDone              <= 1'b0;
         cmdWrite           <= 1'b0;
         cmdAddr            <= '0;
         cmdWdata           <= '0;
         cmdWstrb           <= '0;
         rspRdata           <= '0;
         rspResp            <= OKAY;
         io_cmd_ready       <= 1'b1;
         io_rsp_valid       <= 1'b0;
         io_axiLite_awvalid <= 1'b0;
         io_axiLite_wvalid  <= 1'b0;
         io_axiLite_bready  <= 1'b0;
         io_axiLite_arvalid <= 1'b0;
         io_axiLite_rready  <= 1'b0;
      end else begin
         state  <= stateNext;
         awDone <= awDoneNext;
         wDone  <= wDoneNext;
         if (cmdFire) begin
            cmdWrite <= io_cmd_write;
            cmdAddr  <= io_cmd_addr;
            cmdWdata <= io_cmd_wdata;
            cmdWstrb <= io_cmd_wstrb;
         end
         // A genuine slave response in the same cycle as the watchdog wins
         if (timeoutHit) begin
            rspResp  <= SLVERR;
            rspRdata <= '0;
         end
         if ((state == WRESP) && bFire) begin
            rspResp  <= io_axiLite_bresp;
            rspRdata <= '0;
         end
         if ((state == RDATA) && rFire) begin
            rspResp  <= io_axiLite_rresp;
            rspRdata <= io_axiLite_rdata;
         end
         io_cmd_ready       <= (stateNext == IDLE);
         io_rsp_valid       <= (stateNext == RSP);
         io_axiLite_awvalid <= (stateNext == WADDR) && !awDoneNext;
         io_axiLite_wvalid  <= (stateNext == WADDR) && !wDoneNext;
         io_axiLite_bready  <= (stateNext == WRESP) || (LATE_DRAIN && (stateNext == IDLE));
         io_axiLite_arvalid <= (stateNext == RADDR);
         io_axiLite_rready  <= (stateNext == RDATA) || (LATE_DRAIN && (stateNext == IDLE));
      end
   end

   assign io_axiLite_awaddr = cmdAddr;
   assign io_axiLite_awprot = 3'b000;
   assign io_axiLite_wdata  = cmdWdata;
   assign io_axiLite_wstrb  = cmdWstrb;
   assign io_axiLite_araddr = cmdAddr;
   assign io_axiLite_arprot = 3'b000;

   assign io_rsp_rdata = rspRdata;
   assign io_rsp_resp  = rspResp;
   assign io_rsp_write = cmdWrite;

endmodule

// File: tb/tb_axil_master_cmd.sv
// Scoreboard bench for axil_master_cmd: directed commands against a configurable AXI-Lite slave model.
module tb_axil_master_cmd;
   import axil_pkg::*;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   typedef struct packed {
      logic          write;
      logic [1:0]    resp;
      logic [DW-1:0] rdata;
   } rsp_t;

   logic clock = 1'b0;
   logic reset;
   logic io_cmd_valid, io_cmd_ready, io_cmd_write;
   logic [AW-1:0] io_cmd_addr;
   logic [DW-1:0] io_cmd_wdata;
   logic [SW-1:0] io_cmd_wstrb;
   logic io_rsp_valid, io_rsp_ready, io_rsp_write;
   logic [DW-1:0] io_rsp_rdata;
   logic [1:0] io_rsp_resp;
   logic [AW-1:0] io_axiLite_awaddr, io_axiLite_araddr;
   logic [2:0] io_axiLite_awprot, io_axiLite_arprot;
   logic io_axiLite_awvalid, io_axiLite_awready, io_axiLite_wvalid, io_axiLite_wready;
   logic [DW-1:0] io_axiLite_wdata, io_axiLite_rdata;
   logic [SW-1:0] io_axiLite_wstrb;
   logic [1:0] io_axiLite_bresp, io_axiLite_rresp;
   logic io_axiLite_bvalid, io_axiLite_bready, io_axiLite_arvalid, io_axiLite_arready;
   logic io_axiLite_rvalid, io_axiLite_rready;

   axil_master_cmd #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
      .clock(clock), .reset(reset),
      .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready), .io_cmd_write(io_cmd_write),
      .io_cmd_addr(io_cmd_addr), .io_cmd_wdata(io_cmd_wdata), .io_cmd_wstrb(io_cmd_wstrb),
      .io_rsp_valid(io_rsp_valid), .io_rsp_ready(io_rsp_ready), .io_rsp_rdata(io_rsp_rdata),
      .io_rsp_resp(io_rsp_resp), .io_rsp_write(io_rsp_write),
      .io_axiLite_awaddr(io_axiLite_awaddr), .io_axiLite_awprot(io_axiLite_awprot),
      .io_axiLite_awvalid(io_axiLite_awvalid), .io_axiLite_awready(io_axiLite_awready),
      .io_axiLite_wdata(io_axiLite_wdata), .io_axiLite_wstrb(io_axiLite_wstrb),
      .io_axiLite_wvalid(io_axiLite_wvalid), .io_axiLite_wready(io_axiLite_wready),
      .io_axiLite_bresp(io_axiLite_bresp), .io_axiLite_bvalid(io_axiLite_bvalid),
      .io_axiLite_bready(io_axiLite_bready),
      .io_axiLite_araddr(io_axiLite_araddr), .io_axiLite_arprot(io_axiLite_arprot),
      .io_axiLite_arvalid(io_axiLite_arvalid), .io_axiLite_arready(io_axiLite_arready),
      .io_axiLite_rdata(io_axiLite_rdata), .io_axiLite_rresp(io_axiLite_rresp),
      .io_axiLite_rvalid(io_axiLite_rvalid), .io_axiLite_rready(io_axiLite_rready)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;
   rsp_t expQ[$];

   // Slave configuration, written by the stimulus
   int cfgAwDelay = 0, cfgWDelay = 0, cfgArDelay = 0, cfgRDelay = 0;
   logic [1:0] cfgBresp = 2'b00, cfgRresp = 2'b00;
   logic [DW-1:0] cfgRdata = '0;

   // Slave model state and observation counters
   int awCnt = 0, wCnt = 0, arCnt = 0, rCnt = 0;
   int awHigh = 0, wHigh = 0, arHigh = 0, bFires = 0, stabViol = 0;
   logic awGot = 0, wGot = 0, rPend = 0;
   logic pAwv = 0, pWv = 0, pArv = 0, pBrdy = 0, pRrdy = 0;
   logic [AW-1:0] pAwaddr = '0, pAraddr = '0;
   logic [DW-1:0] pWdata = '0;
   logic [SW-1:0] pWstrb = '0;

   // Slave: decides handshakes from what was visible before the last rising edge
   always @(negedge clock) begin
      if (reset) begin
         awGot = 0; wGot = 0; rPend = 0; awCnt = 0; wCnt = 0; arCnt = 0; rCnt = 0;
         pAwv = 0; pWv = 0; pArv = 0; pBrdy = 0; pRrdy = 0;
         io_axiLite_awready = 0; io_axiLite_wready = 0; io_axiLite_arready = 0;
         io_axiLite_bvalid = 0; io_axiLite_bresp = 2'b00;
         io_axiLite_rvalid = 0; io_axiLite_rresp = 2'b00; io_axiLite_rdata = '0;
      end else begin
         if (pAwv && !io_axiLite_awready && (!io_axiLite_awvalid || io_axiLite_awaddr != pAwaddr))
            stabViol++;
         if (pWv && !io_axiLite_wready &&
             (!io_axiLite_wvalid || io_axiLite_wdata != pWdata || io_axiLite_wstrb != pWstrb))
            stabViol++;
         if (pArv && !io_axiLite_arready && (!io_axiLite_arvalid || io_axiLite_araddr != pAraddr))
            stabViol++;
         if (pAwv && io_axiLite_awready) awGot = 1;
         if (pWv && io_axiLite_wready) wGot = 1;
         if (pArv && io_axiLite_arready) begin rPend = 1; rCnt = 0; end
         if (io_axiLite_bvalid && pBrdy) begin bFires++; io_axiLite_bvalid = 0; end
         if (io_axiLite_rvalid && pRrdy) io_axiLite_rvalid = 0;
         if (awGot && wGot && !io_axiLite_bvalid) begin
            io_axiLite_bvalid = 1; io_axiLite_bresp = cfgBresp; awGot = 0; wGot = 0;
         end
         if (rPend && !io_axiLite_rvalid) begin
            if (rCnt >= cfgRDelay) begin
               io_axiLite_rvalid = 1; io_axiLite_rdata = cfgRdata; io_axiLite_rresp = cfgRresp;
               rPend = 0;
            end else rCnt++;
         end
         if (io_axiLite_awvalid) begin awHigh++; awCnt++; end else awCnt = 0;
         if (io_axiLite_wvalid)  begin wHigh++;  wCnt++;  end else wCnt = 0;
         if (io_axiLite_arvalid) begin arHigh++; arCnt++; end else arCnt = 0;
         io_axiLite_awready = (cfgAwDelay == 0) || (io_axiLite_awvalid && awCnt >= cfgAwDelay);
         io_axiLite_wready  = (cfgWDelay == 0)  || (io_axiLite_wvalid && wCnt >= cfgWDelay);
         io_axiLite_arready = (cfgArDelay == 0) || (io_axiLite_arvalid && arCnt >= cfgArDelay);
         pAwv = io_axiLite_awvalid; pAwaddr = io_axiLite_awaddr;
         pWv = io_axiLite_wvalid; pWdata = io_axiLite_wdata; pWstrb = io_axiLite_wstrb;
         pArv = io_axiLite_arvalid; pAraddr = io_axiLite_araddr;
         pBrdy = io_axiLite_bready; pRrdy = io_axiLite_rready;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a response handshake is about to happen
   task automatic monitorRsp();
      rsp_t e;
      forever begin
         @(negedge clock);
         #1;
         if (!reset && io_rsp_valid && io_rsp_ready) begin
            if (expQ.size() == 0) begin
               check("rsp_unexpected", 64'({io_rsp_write, io_rsp_resp, io_rsp_rdata}), 64'(0));
            end else begin
               e = expQ.pop_front();
               check("rsp_fields", 64'({io_rsp_write, io_rsp_resp, io_rsp_rdata}), 64'(e));
            end
         end
      end
   endtask

   function automatic axilCmd_t mkCmd(input logic w, input logic [AW-1:0] a,
                                      input logic [DW-1:0] d, input logic [SW-1:0] s);
      axilCmd_t c;
      c.write = w; c.addr = a; c.wdata = d; c.wstrb = s;
      return c;
   endfunction

   function automatic rsp_t mkRsp(input logic w, input logic [1:0] r, input logic [DW-1:0] d);
      rsp_t x;
      x.write = w; x.resp = r; x.rdata = d;
      return x;
   endfunction

   // Presents a command at a falling edge and returns one falling edge after it fires
   task automatic sendCmd(input axilCmd_t c, input logic [1:0] eResp, input logic [DW-1:0] eRdata);
      int w;
      w = 0;
      io_cmd_valid = 1; io_cmd_write = c.write; io_cmd_addr = c.addr;
      io_cmd_wdata = c.wdata; io_cmd_wstrb = c.wstrb;
      expQ.push_back(mkRsp(c.write, eResp, c.write ? '0 : eRdata));
      while (!io_cmd_ready && w < 100) begin @(negedge clock); w++; end
      check("cmd_accept", 64'(io_cmd_ready), 64'(1));
      @(negedge clock);
      io_cmd_valid = 0;
   endtask

   task automatic waitDone();
      int w;
      w = 0;
      while ((expQ.size() != 0 || !io_cmd_ready) && w < 200) begin @(negedge clock); w++; end
      check("drain", 64'(expQ.size()), 64'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int a0, w0, b0, viol, w;
      logic [DW+2:0] snap;

      reset = 1; io_cmd_valid = 0; io_cmd_write = 0; io_cmd_addr = '0;
      io_cmd_wdata = '0; io_cmd_wstrb = '0; io_rsp_ready = 1;
      fork monitorRsp(); join_none
      repeat (3) @(negedge clock);
      check("rst_ctrl", 64'({io_cmd_ready, io_axiLite_awvalid, io_axiLite_wvalid, io_axiLite_bready,
                             io_axiLite_arvalid, io_axiLite_rready, io_rsp_valid}), 64'(7'b1000000));
      check("rst_data", 64'({io_rsp_rdata, io_rsp_resp, io_rsp_write}), 64'(0));
      check("rst_addr", 64'({io_axiLite_awaddr, io_axiLite_araddr, io_axiLite_awprot, io_axiLite_arprot}), 64'(0));
      reset = 0;
      @(negedge clock);

      // Minimum-latency write
      sendCmd(mkCmd(1'b1, 6'h08, 32'hDEADBEEF, 4'hF), OKAY, '0);
      check("c1_awv_wv", 64'({io_axiLite_awvalid, io_axiLite_wvalid}), 64'(2'b11));
      check("c1_awaddr", 64'(io_axiLite_awaddr), 64'(6'h08));
      check("c1_wdata", 64'({io_axiLite_wdata, io_axiLite_wstrb}), 64'({32'hDEADBEEF, 4'hF}));
      @(negedge clock);
      check("c2_rspv_bready", 64'({io_rsp_valid, io_axiLite_bready}), 64'(2'b01));
      @(negedge clock);
      check("c3_rspv", 64'(io_rsp_valid), 64'(1));
      waitDone();

      // Read with arready delayed
      cfgArDelay = 3; cfgRdata = 32'h12345678; cfgRresp = 2'b00;
      a0 = arHigh;
      sendCmd(mkCmd(1'b0, 6'h10, '0, '0), OKAY, 32'h12345678);
      waitDone();
      check("ar_hold_cycles", 64'(arHigh - a0), 64'(3));
      cfgArDelay = 0;

      // Write with wready delayed 5, SLVERR passed through
      cfgWDelay = 5; cfgBresp = 2'b10;
      a0 = awHigh; w0 = wHigh; b0 = bFires;
      sendCmd(mkCmd(1'b1, 6'h0C, 32'hA5A50F0F, 4'h3), 2'b10, '0);
      waitDone();
      check("aw_cycles", 64'(awHigh - a0), 64'(1));
      check("w_cycles", 64'(wHigh - w0), 64'(5));
      check("b_count", 64'(bFires - b0), 64'(1));
      cfgWDelay = 0; cfgBresp = 2'b00;

      // Response back-pressure with a command waiting
      io_rsp_ready = 0;
      sendCmd(mkCmd(1'b1, 6'h04, 32'h11223344, 4'hC), OKAY, '0);
      w = 0;
      while (!io_rsp_valid && w < 50) begin @(negedge clock); w++; end
      check("bp_rsp_valid", 64'(io_rsp_valid), 64'(1));
      cfgRdata = 32'h55AA55AA;
      io_cmd_valid = 1; io_cmd_write = 0; io_cmd_addr = 6'h14; io_cmd_wdata = '0; io_cmd_wstrb = '0;
      expQ.push_back(mkRsp(1'b0, OKAY, 32'h55AA55AA));
      snap = {io_rsp_rdata, io_rsp_resp, io_rsp_write};
      viol = 0;
      repeat (10) begin
         @(negedge clock);
         if (io_cmd_ready || !io_rsp_valid || {io_rsp_rdata, io_rsp_resp, io_rsp_write} != snap) viol++;
      end
      check("bp_hold", 64'(viol), 64'(0));
      io_rsp_ready = 1;
      @(negedge clock);
      check("cmd_ready_after_rsp", 64'(io_cmd_ready), 64'(1));
      @(negedge clock);
      check("next_cmd_taken", 64'(io_axiLite_arvalid), 64'(1));
      io_cmd_valid = 0;
      waitDone();

      // Read with a non-OKAY rresp
      cfgRdata = 32'h00000001; cfgRresp = 2'b01;
      sendCmd(mkCmd(1'b0, 6'h3C, '0, '0), 2'b01, 32'h00000001);
      waitDone();
      cfgRresp = 2'b00;

      // Reset while waiting in RDATA
      cfgRDelay = 50; cfgRdata = 32'hBAADBAAD;
      sendCmd(mkCmd(1'b0, 6'h20, '0, '0), OKAY, 32'hBAADBAAD);
      repeat (2) @(negedge clock);
      check("in_rdata", 64'({io_axiLite_rready, io_axiLite_arvalid}), 64'(2'b10));
      reset = 1;
      expQ.delete();
      @(negedge clock);
      check("midrst_ctrl", 64'({io_cmd_ready, io_axiLite_awvalid, io_axiLite_wvalid, io_axiLite_bready,
                                io_axiLite_arvalid, io_axiLite_rready, io_rsp_valid}), 64'(7'b1000000));
      check("midrst_data", 64'({io_rsp_rdata, io_rsp_resp}), 64'(0));
      reset = 0;
      cfgRDelay = 0; cfgRdata = 32'hCAFEF00D;
      @(negedge clock);
      sendCmd(mkCmd(1'b0, 6'h2C, '0, '0), OKAY, 32'hCAFEF00D);
      waitDone();

      check("payload_stable", 64'(stabViol), 64'(0));

`ifdef AXIL_MASTER_TIMEOUT_EN
      // Slave never accepts AR: watchdog answers SLVERR after 16 cycles in RADDR
      cfgArDelay = 1000000; cfgRdata = 32'hFFFFFFFF;
      a0 = arHigh;
      sendCmd(mkCmd(1'b0, 6'h30, '0, '0), SLVERR, '0);
      waitDone();
      check("timeout_ar_cycles", 64'(arHigh - a0), 64'(16));
      cfgArDelay = 0;
`endif

      repeat (2) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
